// File: rtl/sc_canon_pkg.sv
// Shared types and helpers for the stochastic-computing canonical-form path.
// Holds the stream FSM state type and the thermometer-code legality check.
package sc_canon_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam int MAX_N = 64;

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Words are zero-extended to MAX_N; n bounds the live bits.
    function automatic logic is_therm(
        input logic [MAX_N-1:0] word,
        input logic             dir,
        input int               n
    );
        logic [MAX_N-1:0] mask;
        logic [MAX_N-1:0] w;
        mask = (n >= MAX_N) ? '1
                            : ((MAX_N'(1) << n) - MAX_N'(1));
        w = dir ? (~word & mask) : (word & mask);
        return (w & (w + MAX_N'(1))) == '0;
    endfunction

endpackage

// File: rtl/therm_rotate.sv
// Combinational barrel rotator: rotated[i] = word[(i+phase) mod N].
// One layer per phase bit, each rotating right by a power of two.
module therm_rotate #(
    parameter int N = 8
) (
    input  logic [N-1:0]         word,
    input  logic [$clog2(N)-1:0] phase,
    output logic [N-1:0]         rotated
);

    localparam int CW = $clog2(N);

    logic [N-1:0] cur;

    always_comb begin
        cur = word;
        for (int l = 0; l < CW; l++) begin
            if (phase[l]) begin
                cur = (cur >> (1 << l)) | (cur << (N - (1 << l)));
            end
        end
        rotated = cur;
    end

endmodule

// File: rtl/therm_to_stream.sv
// Thermometer word to N-beat unary bitstream with rotation phase.
// Flags illegal thermometer words with a pulse aligned to beat 0.
module therm_to_stream
    import sc_canon_pkg::*;
#(
    parameter int N   = 8,
    parameter bit DIR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         therm,
    input  logic [$clog2(N)-1:0] phase,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bit,
    output logic                 out_last,
    output logic                 bad_code
);

    localparam int CW = cw_of(N);

    stream_state_t state;
    logic [N-1:0]  sreg;
    logic [N-1:0]  rot;
    logic [CW-1:0] cnt;
    logic          bad_q;
    logic          accept;
    logic          beat;
    logic          legal;

    therm_rotate #(.N(N)) u_rot (
        .word    (therm),
        .phase   (phase),
        .rotated (rot)
    );

    assign out_valid = (state == STREAM);
    assign out_last  = out_valid && (cnt == CW'(N - 1));
    assign out_bit   = sreg[0];
    assign bad_code  = bad_q;

    // Refill is allowed on the last beat so consecutive words abut.
    assign in_ready = (state == IDLE) || (out_last && out_ready);
    assign accept   = in_valid && in_ready;
    assign beat     = out_valid && out_ready;
    assign legal    = is_therm(MAX_N'(therm), DIR, N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            bad_q <= 1'b0;
        end else begin
            bad_q <= accept && !legal;
            if (accept) begin
                state <= STREAM;
                sreg  <= rot;
                cnt   <= '0;
            end else if (beat) begin
                sreg <= sreg >> 1;
                cnt  <= cnt + CW'(1);
                if (out_last) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_therm_to_stream.sv
// Scoreboard bench for therm_to_stream: DIR=0 and DIR=1 instances, N=8.
// Directed words with hand-computed beat sequences (bit k = beat k).
module tb_therm_to_stream;

    typedef struct {
        logic b;
        logic last;
        logic bad;
        int   k;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       out_ready = 1'b1;
    logic       bp_en = 1'b0;
    int         bp_cnt = 0;

    logic       iv0 = 1'b0, iv1 = 1'b0;
    logic [7:0] th0 = '0, th1 = '0;
    logic [2:0] ph0 = '0, ph1 = '0;
    logic       ir0, ir1, ov0, ov1, ob0, ob1, ol0, ol1, bc0, bc1;

    int   n_vec = 0;
    int   n_bad = 0;
    ent_t q [2][$];
    logic held [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    therm_to_stream #(.N(8), .DIR(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv0), .in_ready(ir0),
        .therm(th0), .phase(ph0),
        .out_valid(ov0), .out_ready(out_ready),
        .out_bit(ob0), .out_last(ol0), .bad_code(bc0)
    );

    therm_to_stream #(.N(8), .DIR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(ir1),
        .therm(th1), .phase(ph1),
        .out_valid(ov1), .out_ready(out_ready),
        .out_bit(ob1), .out_last(ol1), .bad_code(bc1)
    );

    always @(negedge clk) begin
        if (bp_en) begin
            out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3);
            bp_cnt++;
        end else begin
            out_ready = 1'b1;
            bp_cnt = 0;
        end
    end

    task automatic expect1(input string name, input logic act,
                           input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic chk(input int d, input logic v, input logic b,
                       input logic l, input logic bad);
        ent_t e;
        logic exp_bc;
        if (!v) begin
            expect1($sformatf("idle_last_bad%0d", d), l | bad, 1'b0);
            held[d] = 1'b0;
        end else if (q[d].size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_beat%0d: got bit %b, want no beat at %0t",
                     d, b, $time);
            held[d] = !out_ready;
        end else begin
            e = q[d][0];
            expect1($sformatf("bit%0d_k%0d", d, e.k), b, e.b);
            expect1($sformatf("last%0d_k%0d", d, e.k), l, e.last);
            exp_bc = (e.k == 0 && !held[d]) ? e.bad : 1'b0;
            expect1($sformatf("bad%0d_k%0d", d, e.k), bad, exp_bc);
            if (out_ready) void'(q[d].pop_front());
            held[d] = !out_ready;
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        chk(0, ov0, ob0, ol0, bc0);
        chk(1, ov1, ob1, ol1, bc1);
    end

    task automatic send(input int d, input logic [7:0] t,
                        input logic [2:0] p, input logic [7:0] exp,
                        input logic exp_bad);
        bit ok;
        logic rdy;
        ok = 0;
        @(negedge clk);
        if (d == 0) begin iv0 = 1; th0 = t; ph0 = p; end
        else        begin iv1 = 1; th1 = t; ph1 = p; end
        for (int c = 0; c < 64 && !ok; c++) begin
            #1;
            rdy = (d == 0) ? ir0 : ir1;
            if (rdy) begin
                for (int k = 0; k < 8; k++)
                    q[d].push_back('{b: exp[k], last: (k == 7),
                                     bad: exp_bad, k: k});
                ok = 1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout%0d: word %h never accepted", d, t);
        end
        #1;
        if (d == 0) begin iv0 = 0; ph0 = ~p; end
        else        begin iv1 = 0; ph1 = ~p; end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (q[0].size() != 0 || q[1].size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending %0d/%0d beats, want 0/0",
                     q[0].size(), q[1].size());
        end
    endtask

    task automatic check_reset_vals(input string tag);
        expect1({tag, "_valid"}, ov0 | ov1, 1'b0);
        expect1({tag, "_bit"}, ob0 | ob1, 1'b0);
        expect1({tag, "_last"}, ol0 | ol1, 1'b0);
        expect1({tag, "_bad"}, bc0 | bc1, 1'b0);
        expect1({tag, "_ready"}, ir0 & ir1, 1'b1);
    endtask

    initial begin
        #3;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 8'b00001111, 3'd0, 8'b00001111, 1'b0);
        send(0, 8'b00001111, 3'd2, 8'b11000011, 1'b0);
        send(1, 8'b11100000, 3'd0, 8'b11100000, 1'b0);
        send(1, 8'b11010000, 3'd4, 8'b00001101, 1'b1);
        send(1, 8'b00000000, 3'd3, 8'b00000000, 1'b0);
        drain();

        send(0, 8'b00111111, 3'd0, 8'b00111111, 1'b0);
        send(0, 8'b00000011, 3'd0, 8'b00000011, 1'b0);
        send(0, 8'b00101111, 3'd0, 8'b00101111, 1'b1);
        send(0, 8'b10000000, 3'd7, 8'b00000001, 1'b1);
        send(0, 8'b11111111, 3'd5, 8'b11111111, 1'b0);
        drain();

        bp_en = 1'b1;
        send(0, 8'b00001111, 3'd1, 8'b10000111, 1'b0);
        send(0, 8'b00101111, 3'd3, 8'b11100101, 1'b1);
        drain();
        bp_en = 1'b0;
        @(negedge clk);

        send(0, 8'b00001111, 3'd0, 8'b00001111, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #3;
        check_reset_vals("mid_rst");
        q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'b00000111, 3'd0, 8'b00000111, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
